// File: rtl/secuenciador_bus_rtc_if.sv
// Request/grant bus between the RTC requesters and the bus sequencer.
interface secuenciador_bus_rtc_if;
  logic       sol_inicio;
  logic       sol_escribir;
  logic       sol_leer;
  logic [7:0] dir_in;
  logic [7:0] dato_in;
  logic       enable_inicio;
  logic       enable_escribir;
  logic       enable_leer;
  logic [3:0] estado;
  logic [7:0] dir_out;
  logic [7:0] dato_out;
  logic       ocupado;
  logic       fin;

  // Requester side: raises requests, sees grant and phase.
  modport master (
    output sol_inicio, sol_escribir, sol_leer, dir_in, dato_in,
    input  enable_inicio, enable_escribir, enable_leer, estado,
    input  dir_out, dato_out, ocupado, fin
  );

  // Sequencer side.
  modport slave (
    input  sol_inicio, sol_escribir, sol_leer, dir_in, dato_in,
    output enable_inicio, enable_escribir, enable_leer, estado,
    output dir_out, dato_out, ocupado, fin
  );
endinterface

// File: rtl/secuenciador_bus_rtc.sv
// Fixed-priority arbiter and 12-phase sequencer for the multiplexed RTC bus.
module secuenciador_bus_rtc #(
  parameter int unsigned CICLOS_FASE = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  secuenciador_bus_rtc_if.slave bus
);

  localparam int unsigned DIV_W       = 4;
  localparam int unsigned ESTADO_W    = 4;
  localparam logic [DIV_W-1:0]    DIV_MAX     = DIV_W'(CICLOS_FASE - 1);
  localparam logic [ESTADO_W-1:0] ULTIMA_FASE = ESTADO_W'(11);

  typedef enum logic [1:0] {
    REPOSO = 2'd0,
    FASE   = 2'd1,
    FIN    = 2'd2
  } fsm_t;

  fsm_t                state, state_n;
  logic                en_ini, en_ini_n;
  logic                en_esc, en_esc_n;
  logic                en_lee, en_lee_n;
  logic [ESTADO_W-1:0] estado_q, estado_n;
  logic [DIV_W-1:0]    div, div_n;
  logic [7:0]          dir_q, dir_n;
  logic [7:0]          dato_q, dato_n;
  logic                ocupado_q, ocupado_n;
  logic                fin_q, fin_n;
  logic                grant;

  // State and registered outputs, synchronous reset clears everything.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= REPOSO;
      en_ini    <= 1'b0;
      en_esc    <= 1'b0;
      en_lee    <= 1'b0;
      estado_q  <= '0;
      div       <= '0;
      dir_q     <= '0;
      dato_q    <= '0;
      ocupado_q <= 1'b0;
      fin_q     <= 1'b0;
    end else begin
      state     <= state_n;
      en_ini    <= en_ini_n;
      en_esc    <= en_esc_n;
      en_lee    <= en_lee_n;
      estado_q  <= estado_n;
      div       <= div_n;
      dir_q     <= dir_n;
      dato_q    <= dato_n;
      ocupado_q <= ocupado_n;
      fin_q     <= fin_n;
    end
  end

  // Next state and next output values: grant in REPOSO, phase stepping in FASE.
  always_comb begin
    state_n   = state;
    en_ini_n  = en_ini;
    en_esc_n  = en_esc;
    en_lee_n  = en_lee;
    estado_n  = estado_q;
    div_n     = div;
    dir_n     = dir_q;
    dato_n    = dato_q;
    ocupado_n = ocupado_q;
    fin_n     = 1'b0;
    grant     = 1'b0;

    unique case (state)
      REPOSO: begin
        en_ini_n  = 1'b0;
        en_esc_n  = 1'b0;
        en_lee_n  = 1'b0;
        estado_n  = '0;
        div_n     = '0;
        ocupado_n = 1'b0;
        if (bus.sol_inicio) begin
          en_ini_n = 1'b1;
          grant    = 1'b1;
        end else if (bus.sol_escribir) begin
          en_esc_n = 1'b1;
          grant    = 1'b1;
        end else if (bus.sol_leer) begin
          en_lee_n = 1'b1;
          grant    = 1'b1;
        end
        if (grant) begin
          ocupado_n = 1'b1;
          dir_n     = bus.dir_in;
          dato_n    = bus.dato_in;
          state_n   = FASE;
        end
      end

      FASE: begin
        if (div == DIV_MAX) begin
          div_n = '0;
          if (estado_q == ULTIMA_FASE) begin
            state_n  = FIN;
            en_ini_n = 1'b0;
            en_esc_n = 1'b0;
            en_lee_n = 1'b0;
            estado_n = '0;
            fin_n    = 1'b1;
          end else begin
            estado_n = estado_q + ESTADO_W'(1);
          end
        end else begin
          div_n = div + DIV_W'(1);
        end
      end

      FIN: begin
        state_n   = REPOSO;
        ocupado_n = 1'b0;
      end

      default: begin
        state_n = REPOSO;
      end
    endcase
  end

  assign bus.enable_inicio   = en_ini;
  assign bus.enable_escribir = en_esc;
  assign bus.enable_leer     = en_lee;
  assign bus.estado          = estado_q;
  assign bus.dir_out         = dir_q;
  assign bus.dato_out        = dato_q;
  assign bus.ocupado         = ocupado_q;
  assign bus.fin             = fin_q;

endmodule
